trace_replay: RTL and testbench
===============================

Name: trace_replay

Overview:
- Reads back lane-trace records of the form (sim_time, type_h, data) and re-drives the rx/tx lane buses cycle by cycle for replay-driven benches.
- Input records come from a DPI-fed record FIFO over a valid/ready port.
- Six records, type 0..5, form one trace cycle. Records with equal time are assembled into a frame, gaps between timestamps are filled, and each replayed cycle is marked with rpl_valid.

Parameters:
- LANS, 4, number of lanes
- WIDTH, 'h044444, packed width code; BYTES = WIDTH>>16 bytes per lane
- GAP_LIMIT, 1024, largest timestamp gap that is filled cycle by cycle; larger gaps are skipped

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rec_valid  in  1  record present
- rec_ready  out  1  record accepted when rec_valid && rec_ready
- rec_time  in  64  trace cycle of the record
- rec_type  in  6  record type: 0 rdat, 1 rdatk, 2 rdatv, 3 tdat, 4 tdatk, 5 tdatv
- rec_data  in  544  payload, LSB-aligned; unused upper bits ignored
- rpl_valid  out  1  replayed cycle strobe
- rpl_time  out  64  trace cycle currently driven
- rdat, tdat  out  LANS*BYTES*8  replayed data
- rdatk, tdatk  out  LANS*BYTES  replayed K flags
- rdatv, tdatv  out  LANS  replayed lane valids
- err  out  3  sticky errors: [0] type order, [1] time mismatch in frame, [2] time regression
- frame_cnt  out  32  frames emitted

Behaviour:
- Reset (rst_n=0 at posedge):
  - All outputs are 0 and rec_ready=0.
  - Replay counter cnt=0, state COLLECT, expected type exp=0.
- Output registers: all outputs are registered. The data driven in the cycle after an edge is the data loaded at that edge.
- COLLECT:
  - rec_ready=1.
  - Type 0 accepted: latch ftime=rec_time, store slot 0, exp=1.
  - Type k>0 accepted: must have rec_type==exp and rec_time==ftime.
  - Wrong type: set err[0], drop the partial frame, exp=0. If the offending record is type 0, it starts a new frame.
  - Wrong time: set err[1], drop the partial frame, exp=0.
  - Type 5 accepted correctly: rec_ready=0 from the next cycle, then evaluate the completed frame:
    - ftime < cnt: set err[2], discard the frame, return to COLLECT.
    - ftime == cnt: go to EMIT.
    - 0 < ftime-cnt <= GAP_LIMIT: go to GAP.
    - ftime-cnt > GAP_LIMIT: cnt := ftime, go to EMIT (skip, no fill cycles).
- GAP:
  - Each cycle: rpl_valid=1, rpl_time=cnt, lane outputs idle, cnt++.
  - Leave for EMIT when cnt+1 == ftime.
- EMIT:
  - One cycle: rpl_valid=1, rpl_time=ftime, lane outputs = frame slots (truncated to port widths).
  - cnt := ftime+1, frame_cnt++ (saturates at 2^32-1).
  - Next state COLLECT.
- rpl_valid=0 in all other cycles.
- Throughput: at most one record per cycle, so one frame per 7 clocks minimum. Replay time advances only on rpl_valid cycles.
- Counters: cnt wraps at 2^64 (unreachable in practice). err bits are cleared only by reset.
- Reset mid-frame: partial frame discarded, cnt=0, outputs zeroed on the same edge.

Optional Feature:
- TRACE_REPLAY_HOLD_EN defined: GAP cycles hold the last emitted lane values. Before the first frame, GAP cycles drive 0.
- TRACE_REPLAY_HOLD_EN undefined: GAP cycles drive all lane outputs 0.

Decomposition:
- Package trace_pkg:
  - rec_type_e enum (REC_RDAT=0 .. REC_TDATV=5)
  - TIME_W=64, TYPE_W=6, REC_DATA_W=544
  - functions dat_w(LANS,WIDTH), k_w(LANS,WIDTH)
  - err bit index constants
- Sub-module trace_frame_asm:
  - Owns the type/time checks, six slot registers, ftime and frame_done.
  - trace_replay keeps cnt, the COLLECT/GAP/EMIT FSM and the output registers.

Test Plan:
- Frame t=0 with types 0..5 in order (rdat=0x11..., rdatv=4'hF) -> one rpl_valid cycle, rpl_time=0, lanes match, frame_cnt=1, err=0.
- Frames t=0 then t=3 -> rpl_valid cycles with rpl_time 0,1,2,3; times 1 and 2 carry lanes 0 (frame-0 values with HOLD_EN); frame 2 data at time 3.
- Records type 0, 1, 3 -> err[0]=1, frame dropped, no rpl_valid; a following correct frame replays normally.
- Type 2 record with time ftime+1 -> err[1]=1, frame dropped; frame t=5 after frame t=5 already emitted -> err[2]=1, no emit.
- Frame t=5000 with cnt=1 and GAP_LIMIT=1024 -> no fill cycles, single rpl_valid with rpl_time=5000; next frame t=5001 emits immediately.
- rst_n low for one cycle after type 3 -> all outputs 0 and cnt=0; a fresh frame t=0 replays with rpl_time=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types, widths and helpers for the lane-trace replay block.
package trace_pkg;

  localparam int TIME_W     = 64;
  localparam int TYPE_W     = 6;
  localparam int REC_DATA_W = 544;
  localparam int ERR_W      = 3;

  localparam int ERR_TYPE = 0;
  localparam int ERR_TIME = 1;
  localparam int ERR_REGR = 2;

  typedef enum logic [TYPE_W-1:0] {
    REC_RDAT  = 6'd0,
    REC_RDATK = 6'd1,
    REC_RDATV = 6'd2,
    REC_TDAT  = 6'd3,
    REC_TDATK = 6'd4,
    REC_TDATV = 6'd5
  } rec_type_e;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_GAP,
    ST_EMIT
  } rpl_state_e;

  // WIDTH carries bytes-per-lane in bits [23:16]
  function automatic int dat_w(input int lans, input int width);
    return lans * (width >> 16) * 8;
  endfunction

  function automatic int k_w(input int lans, input int width);
    return lans * (width >> 16);
  endfunction

endpackage

// File: rtl/trace_replay_if.sv
// Record stream from the trace FIFO: valid/ready plus time, type and payload.
interface trace_replay_if;
  import trace_pkg::*;

  logic                  rec_valid;
  logic                  rec_ready;
  logic [TIME_W-1:0]     rec_time;
  logic [TYPE_W-1:0]     rec_type;
  logic [REC_DATA_W-1:0] rec_data;

  modport master (output rec_valid, rec_time, rec_type, rec_data, input rec_ready);
  modport slave  (input rec_valid, rec_time, rec_type, rec_data, output rec_ready);

endinterface

// File: rtl/trace_frame_asm.sv
// Assembles six typed records with a common timestamp into one frame; flags order/time errors.
module trace_frame_asm
  import trace_pkg::*;
#(
  parameter int LANS  = 4,
  parameter int WIDTH = 'h044444
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rec_fire,
  input  logic [TIME_W-1:0]            rec_time,
  input  logic [TYPE_W-1:0]            rec_type,
  input  logic [REC_DATA_W-1:0]        rec_data,
  output logic [dat_w(LANS,WIDTH)-1:0] slot_rdat,
  output logic [k_w(LANS,WIDTH)-1:0]   slot_rdatk,
  output logic [LANS-1:0]              slot_rdatv,
  output logic [dat_w(LANS,WIDTH)-1:0] slot_tdat,
  output logic [k_w(LANS,WIDTH)-1:0]   slot_tdatk,
  output logic [LANS-1:0]              slot_tdatv,
  output logic [TIME_W-1:0]            ftime,
  output logic                         frame_done,
  output logic                         last_ok,
  output logic                         err_type_set,
  output logic                         err_time_set
);

  localparam int DW = dat_w(LANS, WIDTH);
  localparam int KW = k_w(LANS, WIDTH);

  logic [2:0] exp_q;
  logic       is_first;
  logic       type_ok;
  logic       time_ok;
  logic       store_k;
  logic       unused_data;

  assign unused_data  = ^rec_data[REC_DATA_W-1:DW];
  assign is_first     = (rec_type == REC_RDAT);
  assign type_ok      = (rec_type == TYPE_W'(exp_q));
  assign time_ok      = (rec_time == ftime);
  assign err_type_set = rec_fire && !type_ok;
  assign err_time_set = rec_fire && type_ok && (exp_q != 3'd0) && !time_ok;
  assign store_k      = rec_fire && type_ok && (exp_q != 3'd0) && time_ok;
  assign last_ok      = store_k && (exp_q == 3'd5);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q      <= 3'd0;
      ftime      <= '0;
      frame_done <= 1'b0;
      slot_rdat  <= '0;
      slot_rdatk <= '0;
      slot_rdatv <= '0;
      slot_tdat  <= '0;
      slot_tdatk <= '0;
      slot_tdatv <= '0;
    end else begin
      frame_done <= last_ok;
      // a type-0 record always opens a fresh frame, even after an ordering error
      if (rec_fire && is_first) begin
        ftime     <= rec_time;
        slot_rdat <= rec_data[DW-1:0];
        exp_q     <= 3'd1;
      end else if (store_k) begin
        case (rec_type)
          REC_RDATK: slot_rdatk <= rec_data[KW-1:0];
          REC_RDATV: slot_rdatv <= rec_data[LANS-1:0];
          REC_TDAT:  slot_tdat  <= rec_data[DW-1:0];
          REC_TDATK: slot_tdatk <= rec_data[KW-1:0];
          REC_TDATV: slot_tdatv <= rec_data[LANS-1:0];
          default:   ;
        endcase
        exp_q <= (exp_q == 3'd5) ? 3'd0 : exp_q + 3'd1;
      end else if (rec_fire) begin
        exp_q <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/trace_replay.sv
// Replays assembled trace frames cycle by cycle, filling or skipping timestamp gaps.
// Build option TRACE_REPLAY_HOLD_EN: gap cycles hold the last emitted lane values instead of 0.
module trace_replay
  import trace_pkg::*;
#(
  parameter int LANS      = 4,
  parameter int WIDTH     = 'h044444,
  parameter int GAP_LIMIT = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  trace_replay_if.slave                rec,
  output logic                         rpl_valid,
  output logic [TIME_W-1:0]            rpl_time,
  output logic [dat_w(LANS,WIDTH)-1:0] rdat,
  output logic [k_w(LANS,WIDTH)-1:0]   rdatk,
  output logic [LANS-1:0]              rdatv,
  output logic [dat_w(LANS,WIDTH)-1:0] tdat,
  output logic [k_w(LANS,WIDTH)-1:0]   tdatk,
  output logic [LANS-1:0]              tdatv,
  output logic [ERR_W-1:0]             err,
  output logic [31:0]                  frame_cnt
);

  localparam int DW = dat_w(LANS, WIDTH);
  localparam int KW = k_w(LANS, WIDTH);

  rpl_state_e        state;
  logic [TIME_W-1:0] cnt;
  logic [TIME_W-1:0] diff;
  logic              rec_ready_q;
  logic              rec_fire;
  logic              do_emit;
  logic              do_gap;
  logic              regress;

  logic [DW-1:0]     slot_rdat, slot_tdat;
  logic [KW-1:0]     slot_rdatk, slot_tdatk;
  logic [LANS-1:0]   slot_rdatv, slot_tdatv;
  logic [TIME_W-1:0] ftime;
  logic              frame_done, last_ok, err_type_set, err_time_set;

  assign rec.rec_ready = rec_ready_q;
  assign rec_fire      = rec.rec_valid && rec_ready_q;

  trace_frame_asm #(.LANS(LANS), .WIDTH(WIDTH)) u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .rec_fire     (rec_fire),
    .rec_time     (rec.rec_time),
    .rec_type     (rec.rec_type),
    .rec_data     (rec.rec_data),
    .slot_rdat    (slot_rdat),
    .slot_rdatk   (slot_rdatk),
    .slot_rdatv   (slot_rdatv),
    .slot_tdat    (slot_tdat),
    .slot_tdatk   (slot_tdatk),
    .slot_tdatv   (slot_tdatv),
    .ftime        (ftime),
    .frame_done   (frame_done),
    .last_ok      (last_ok),
    .err_type_set (err_type_set),
    .err_time_set (err_time_set)
  );

  // frame evaluation happens in the COLLECT cycle after the type-5 record lands
  always_comb begin
    diff    = ftime - cnt;
    do_emit = 1'b0;
    do_gap  = 1'b0;
    regress = 1'b0;
    case (state)
      ST_COLLECT: begin
        if (frame_done) begin
          if (ftime < cnt)                                    regress = 1'b1;
          else if (diff == '0 || diff > TIME_W'(GAP_LIMIT))   do_emit = 1'b1;
          else                                                do_gap  = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == ftime) do_emit = 1'b1;
        else              do_gap  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_COLLECT;
      cnt         <= '0;
      rec_ready_q <= 1'b0;
      rpl_valid   <= 1'b0;
      rpl_time    <= '0;
      rdat        <= '0;
      rdatk       <= '0;
      rdatv       <= '0;
      tdat        <= '0;
      tdatk       <= '0;
      tdatv       <= '0;
      err         <= '0;
      frame_cnt   <= '0;
    end else begin
      rpl_valid      <= 1'b0;
      err[ERR_TYPE]  <= err[ERR_TYPE] | err_type_set;
      err[ERR_TIME]  <= err[ERR_TIME] | err_time_set;
      err[ERR_REGR]  <= err[ERR_REGR] | regress;
      if (do_emit) begin
        state       <= ST_EMIT;
        rec_ready_q <= 1'b0;
        rpl_valid   <= 1'b1;
        rpl_time    <= ftime;
        rdat        <= slot_rdat;
        rdatk       <= slot_rdatk;
        rdatv       <= slot_rdatv;
        tdat        <= slot_tdat;
        tdatk       <= slot_tdatk;
        tdatv       <= slot_tdatv;
        cnt         <= ftime + TIME_W'(1);
        if (frame_cnt != '1) frame_cnt <= frame_cnt + 32'd1;
      end else if (do_gap) begin
        state       <= ST_GAP;
        rec_ready_q <= 1'b0;
        rpl_valid   <= 1'b1;
        rpl_time    <= cnt;
        cnt         <= cnt + TIME_W'(1);
`ifndef TRACE_REPLAY_HOLD_EN
        rdat        <= '0;
        rdatk       <= '0;
        rdatv       <= '0;
        tdat        <= '0;
        tdatk       <= '0;
        tdatv       <= '0;
`endif
      end else if (state == ST_EMIT) begin
        state       <= ST_COLLECT;
        rec_ready_q <= 1'b1;
      end else begin
        rec_ready_q <= !last_ok;
      end
    end
  end

endmodule

// File: tb/tb_trace_replay.sv
// Directed bench for trace_replay: frames, gap fill/skip, error flags and mid-frame reset.
module tb_trace_replay;

  localparam int LANS      = 4;
  localparam int WIDTH     = 'h044444;
  localparam int GAP_LIMIT = 1024;
  localparam int DW        = 128;
  localparam int KW        = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rpl_valid;
  logic [63:0]       rpl_time;
  logic [DW-1:0]     rdat, tdat;
  logic [KW-1:0]     rdatk, tdatk;
  logic [LANS-1:0]   rdatv, tdatv;
  logic [2:0]        err;
  logic [31:0]       frame_cnt;

  trace_replay_if rif ();

  trace_replay #(.LANS(LANS), .WIDTH(WIDTH), .GAP_LIMIT(GAP_LIMIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rec       (rif),
    .rpl_valid (rpl_valid),
    .rpl_time  (rpl_time),
    .rdat      (rdat),
    .rdatk     (rdatk),
    .rdatv     (rdatv),
    .tdat      (tdat),
    .tdatk     (tdatk),
    .tdatv     (tdatv),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [63:0]     t;
    logic [DW-1:0]   rdat;
    logic [KW-1:0]   rdatk;
    logic [LANS-1:0] rdatv;
    logic [DW-1:0]   tdat;
    logic [KW-1:0]   tdatk;
    logic [LANS-1:0] tdatv;
    int              cyc;
  } ent_t;

  ent_t q[$];
  ent_t mon_e;

  always @(negedge clk) begin
    if (rpl_valid) begin
      mon_e.t     = rpl_time;
      mon_e.rdat  = rdat;
      mon_e.rdatk = rdatk;
      mon_e.rdatv = rdatv;
      mon_e.tdat  = tdat;
      mon_e.tdatk = tdatk;
      mon_e.tdatv = tdatv;
      mon_e.cyc   = cyc;
      q.push_back(mon_e);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // payload with junk above each field's width so truncation is exercised
  function automatic logic [543:0] payload(input int ty, input logic [7:0] s);
    logic [543:0] d;
    logic [7:0]   ns;
    ns = ~s;
    d  = '0;
    case (ty)
      0: d[127:0] = {16{s}};
      1: d[15:0]  = {2{s}};
      2: d[3:0]   = s[3:0];
      3: d[127:0] = {16{ns}};
      4: d[15:0]  = {2{ns}};
      5: d[3:0]   = ns[3:0];
      default: d = '0;
    endcase
    if (ty == 1 || ty == 2 || ty == 4 || ty == 5) d[127:64] = '1;
    d[543:528] = 16'hDEAD;
    return d;
  endfunction

  task automatic send_rec(input logic [63:0] t, input int ty, input logic [7:0] s);
    bit ok;
    ok = 1'b0;
    rif.rec_time  = t;
    rif.rec_type  = 6'(ty);
    rif.rec_data  = payload(ty, s);
    rif.rec_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rif.rec_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("rec_ready_seen", 128'(ok), 128'd1);
    if (ok) @(posedge clk);
    #1;
    rif.rec_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] t, input logic [7:0] s);
    for (int ty = 0; ty < 6; ty++) send_rec(t, ty, s);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // idle entries expect zero lanes, or the seed's lanes when gap cycles hold
  task automatic check_ent(input string tag, input int idx, input logic [63:0] t,
                           input logic [7:0] s, input bit idle);
    logic [7:0] ns;
    bit         zero;
    ns   = ~s;
    zero = idle;
`ifdef TRACE_REPLAY_HOLD_EN
    zero = 1'b0;
`endif
    check_val({tag, "_present"}, 128'(q.size() > idx), 128'd1);
    if (q.size() > idx) begin
      check_val({tag, "_time"},  q[idx].t,     t);
      check_val({tag, "_rdat"},  q[idx].rdat,  zero ? 128'd0 : 128'({16{s}}));
      check_val({tag, "_rdatk"}, q[idx].rdatk, zero ? 128'd0 : 128'({2{s}}));
      check_val({tag, "_rdatv"}, q[idx].rdatv, zero ? 128'd0 : 128'(s[3:0]));
      check_val({tag, "_tdat"},  q[idx].tdat,  zero ? 128'd0 : 128'({16{ns}}));
      check_val({tag, "_tdatk"}, q[idx].tdatk, zero ? 128'd0 : 128'({2{ns}}));
      check_val({tag, "_tdatv"}, q[idx].tdatv, zero ? 128'd0 : 128'(ns[3:0]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rpl_valid"}, rpl_valid, 0);
    check_val({tag, "_rpl_time"},  rpl_time, 0);
    check_val({tag, "_rdat"},      rdat, 0);
    check_val({tag, "_tdatv"},     tdatv, 0);
    check_val({tag, "_err"},       err, 0);
    check_val({tag, "_frame_cnt"}, frame_cnt, 0);
    check_val({tag, "_rec_ready"}, rif.rec_ready, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rif.rec_valid = 1'b0;
    rif.rec_time  = '0;
    rif.rec_type  = '0;
    rif.rec_data  = '0;
    rst_n = 1'b0;
    wait_cycles(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // single frame at t=0
    q.delete();
    send_frame(64'd0, 8'h11);
    wait_cycles(8);
    check_val("f0_count", q.size(), 1);
    check_ent("f0", 0, 64'd0, 8'h11, 1'b0);
    check_val("f0_frame_cnt", frame_cnt, 1);
    check_val("f0_err", err, 0);

    // t=3 after t=0: fill cycles at 1 and 2
    q.delete();
    send_frame(64'd3, 8'h22);
    wait_cycles(10);
    check_val("gap3_count", q.size(), 3);
    check_ent("gap3_t1", 0, 64'd1, 8'h11, 1'b1);
    check_ent("gap3_t2", 1, 64'd2, 8'h11, 1'b1);
    check_ent("gap3_t3", 2, 64'd3, 8'h22, 1'b0);
    if (q.size() == 3) check_val("gap3_contig", q[2].cyc - q[0].cyc, 2);
    check_val("gap3_frame_cnt", frame_cnt, 2);

    // out-of-order types
    q.delete();
    send_rec(64'd10, 0, 8'h33);
    send_rec(64'd10, 1, 8'h33);
    send_rec(64'd10, 3, 8'h33);
    wait_cycles(4);
    check_val("order_err", err, 3'b001);
    check_val("order_no_rpl", q.size(), 0);
    send_frame(64'd4, 8'h44);
    wait_cycles(8);
    check_val("order_next_count", q.size(), 1);
    check_ent("order_next", 0, 64'd4, 8'h44, 1'b0);
    check_val("order_next_frame_cnt", frame_cnt, 3);

    // time mismatch inside a frame, then regression
    q.delete();
    send_rec(64'd5, 0, 8'h55);
    send_rec(64'd5, 1, 8'h55);
    send_rec(64'd6, 2, 8'h55);
    wait_cycles(4);
    check_val("time_err", err, 3'b011);
    check_val("time_no_rpl", q.size(), 0);
    send_frame(64'd5, 8'h55);
    wait_cycles(8);
    check_val("t5_count", q.size(), 1);
    check_ent("t5", 0, 64'd5, 8'h55, 1'b0);
    q.delete();
    send_frame(64'd5, 8'h66);
    wait_cycles(8);
    check_val("regr_err", err, 3'b111);
    check_val("regr_no_rpl", q.size(), 0);
    check_val("regr_frame_cnt", frame_cnt, 4);

    // large gap is skipped
    q.delete();
    send_frame(64'd5000, 8'h77);
    wait_cycles(8);
    check_val("skip_count", q.size(), 1);
    check_ent("skip", 0, 64'd5000, 8'h77, 1'b0);
    q.delete();
    send_frame(64'd5001, 8'h88);
    wait_cycles(8);
    check_val("after_skip_count", q.size(), 1);
    check_ent("after_skip", 0, 64'd5001, 8'h88, 1'b0);
    check_val("after_skip_frame_cnt", frame_cnt, 6);

    // gap of exactly GAP_LIMIT is filled (cnt=5002, ftime=6026)
    q.delete();
    send_frame(64'd6026, 8'h99);
    wait_cycles(1040);
    check_val("lim_count", q.size(), 1025);
    check_ent("lim_first", 0, 64'd5002, 8'h88, 1'b1);
    check_ent("lim_lastgap", 1023, 64'd6025, 8'h88, 1'b1);
    check_ent("lim_emit", 1024, 64'd6026, 8'h99, 1'b0);
    if (q.size() == 1025) check_val("lim_contig", q[1024].cyc - q[0].cyc, 1024);
    check_val("lim_frame_cnt", frame_cnt, 7);

    // gap of GAP_LIMIT+1 is skipped (cnt=6027, ftime=7052)
    q.delete();
    send_frame(64'd7052, 8'hAA);
    wait_cycles(8);
    check_val("lim1_count", q.size(), 1);
    check_ent("lim1", 0, 64'd7052, 8'hAA, 1'b0);
    check_val("lim1_frame_cnt", frame_cnt, 8);

    // reset mid-frame
    q.delete();
    for (int ty = 0; ty < 4; ty++) send_rec(64'd7100, ty, 8'hBB);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    send_frame(64'd0, 8'hCC);
    wait_cycles(8);
    check_val("post_rst_count", q.size(), 1);
    check_ent("post_rst", 0, 64'd0, 8'hCC, 1'b0);
    check_val("post_rst_frame_cnt", frame_cnt, 1);
    check_val("post_rst_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
